// File: rtl/mimasuo_attempt_ctrl.sv
// Two-button combination lock sequencer: press framing, code check,
// unlock window, failure counting and alarmed lockout.
module mimasuo_attempt_ctrl #(
  parameter int                  CODE_LEN      = 4,
  parameter logic [CODE_LEN-1:0] PASSWORD      = 4'b1011,
  parameter int                  MAX_FAIL      = 3,
  parameter int                  OPEN_CYCLES   = 50,
  parameter int                  LOCK_CYCLES   = 100,
  parameter int                  ENTRY_TIMEOUT = 200,
  localparam int                 AW = $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          button0,
  input  logic          button1,
  output logic          UNLOCK,
  output logic          ALARM,
  output logic [AW-1:0] attempts_left
);

  localparam int TMAX0 = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMAX  = (TMAX0 > ENTRY_TIMEOUT) ? TMAX0 : ENTRY_TIMEOUT;
  localparam int TW    = $clog2(TMAX) + 1;
  localparam int CW    = $clog2(CODE_LEN + 1);

  localparam logic [TW-1:0] OPEN_END = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_END = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TO_END   = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [AW-1:0] FAIL_MAX = AW'(MAX_FAIL);
  localparam logic [CW-1:0] CNT_FULL = CW'(CODE_LEN);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
  } state_t;

  state_t              state;
  logic                b0_q;
  logic                b1_q;
  logic [CODE_LEN-1:0] shreg;
  logic [CW-1:0]       bit_cnt;
  logic [AW-1:0]       fail_cnt;
  logic [TW-1:0]       timer;

  logic          p0;
  logic          p1;
  logic          is_bit;
  logic          is_clr;
  logic          any_p;
  logic [AW-1:0] fail_nxt;

  assign p0       = button0 & ~b0_q;
  assign p1       = button1 & ~b1_q;
  assign is_bit   = p0 ^ p1;
  assign is_clr   = p0 & p1;
  assign any_p    = p0 | p1;
  assign fail_nxt = fail_cnt + AW'(1);

  // Sampled through reset too, so a button held across reset is not a press.
  always_ff @(posedge clk) begin
    b0_q <= button0;
    b1_q <= button1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      fail_cnt      <= '0;
      timer         <= '0;
      UNLOCK        <= 1'b0;
      ALARM         <= 1'b0;
      attempts_left <= FAIL_MAX;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_bit) begin
            shreg   <= {shreg[CODE_LEN-2:0], p1};
            bit_cnt <= CW'(1);
            timer   <= '0;
            state   <= ENTRY;
          end
        end
        ENTRY: begin
          if (bit_cnt == CNT_FULL) begin
            state <= CHECK;
          end else if (is_clr || (!is_bit && timer == TO_END)) begin
            shreg   <= '0;
            bit_cnt <= '0;
            timer   <= '0;
            state   <= IDLE;
          end else if (is_bit) begin
            shreg   <= {shreg[CODE_LEN-2:0], p1};
            bit_cnt <= bit_cnt + CW'(1);
            timer   <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CHECK: begin
          shreg   <= '0;
          bit_cnt <= '0;
          timer   <= '0;
          if (shreg == PASSWORD) begin
            UNLOCK        <= 1'b1;
            fail_cnt      <= '0;
            attempts_left <= FAIL_MAX;
            state         <= OPEN;
          end else if (fail_nxt == FAIL_MAX) begin
            ALARM         <= 1'b1;
            fail_cnt      <= fail_nxt;
            attempts_left <= '0;
            state         <= LOCKOUT;
          end else begin
            fail_cnt      <= fail_nxt;
            attempts_left <= FAIL_MAX - fail_nxt;
            state         <= IDLE;
          end
        end
        OPEN: begin
          if (any_p || timer == OPEN_END) begin
            UNLOCK <= 1'b0;
            timer  <= '0;
            state  <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        LOCKOUT: begin
          if (timer == LOCK_END) begin
            ALARM         <= 1'b0;
            fail_cnt      <= '0;
            attempts_left <= FAIL_MAX;
            timer         <= '0;
            state         <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mimasuo_attempt_ctrl.sv
// Scoreboard bench for mimasuo_attempt_ctrl: stimulus queues expected
// output changes (edge number + value), a monitor matches every change.
module tb_mimasuo_attempt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       button0;
  logic       button1;
  logic       unlock;
  logic       alarm;
  logic [1:0] al;

  mimasuo_attempt_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .button0      (button0),
    .button1      (button1),
    .UNLOCK       (unlock),
    .ALARM        (alarm),
    .attempts_left(al)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       u;
    logic       a;
    logic [1:0] al;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_e = 0;
  logic [3:0] prev = 4'b1111;
  logic [3:0] cur;
  ev_t  m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cur = {unlock, alarm, al};
    if (cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got u=%b a=%b al=%0d required no change",
                 cyc, unlock, alarm, al);
      end else begin
        m = q.pop_front();
        if (m.cyc != cyc || {m.u, m.a, m.al} !== cur) begin
          errors++;
          $display("FAIL output_event got cyc=%0d u=%b a=%b al=%0d required cyc=%0d u=%b a=%b al=%0d",
                   cyc, unlock, alarm, al, m.cyc, m.u, m.a, m.al);
        end
      end
      prev = cur;
    end
  end

  task automatic push(input int c, input logic u, input logic a, input logic [1:0] l);
    ev_t e;
    e.cyc = c;
    e.u   = u;
    e.a   = a;
    e.al  = l;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic v0, input logic v1);
    button0 = v0;
    button1 = v1;
    @(negedge clk);
    last_e  = cyc;
    button0 = 1'b0;
    button1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic code4(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) press(!c[i], c[i]);
  endtask

  task automatic open_full();
    push(last_e + 2, 1'b1, 1'b0, 2'd3);
    push(last_e + 52, 1'b0, 1'b0, 2'd3);
    idle(55);
  endtask

  task automatic fail_one(input logic [1:0] l);
    code4(4'b0000);
    push(last_e + 2, 1'b0, 1'b0, l);
    idle(3);
  endtask

  int base;

  initial begin
    button0 = 1'b0;
    button1 = 1'b1;
    rst     = 1'b1;
    push(1, 1'b0, 1'b0, 2'd3);
    idle(2);
    rst = 1'b0;
    idle(4);
    button1 = 1'b0;
    idle(2);

    code4(4'b1011);
    open_full();

    fail_one(2'd2);
    fail_one(2'd1);
    code4(4'b0000);
    base = last_e;
    push(base + 2, 1'b0, 1'b1, 2'd0);
    push(base + 102, 1'b0, 1'b0, 2'd3);
    code4(4'b1011);
    press(1'b1, 1'b1);
    while (cyc < base + 105) @(negedge clk);
    code4(4'b1011);
    open_full();

    fail_one(2'd2);
    code4(4'b1011);
    open_full();

    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    button1 = 1'b1;
    idle(10);
    button1 = 1'b0;
    idle(1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    open_full();

    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    idle(210);
    code4(4'b1011);
    open_full();

    code4(4'b1011);
    push(last_e + 2, 1'b1, 1'b0, 2'd3);
    idle(6);
    push(cyc + 1, 1'b0, 1'b0, 2'd3);
    press(1'b1, 1'b0);
    idle(3);
    code4(4'b1011);
    push(last_e + 2, 1'b1, 1'b0, 2'd3);
    idle(10);
    push(cyc + 1, 1'b0, 1'b0, 2'd3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    code4(4'b1011);
    open_full();

    idle(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d outstanding required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
